// File: rtl/vrf_pkg.sv
// Shared types and sizing helpers for the vector register file sequencer.
package vrf_pkg;

    localparam int REG_NUM_DEF = 32;
    localparam int LANES_DEF   = 4;

    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_WAIT, R_EXEC} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_ARM, W_DATA} wr_state_t;

    function automatic int addr_b(input int reg_num);
        return (reg_num > 1) ? $clog2(reg_num) : 1;
    endfunction

    function automatic int elem_b(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/vrf_ctrl_if.sv
// Issue-stage handshake carrying one decoded vector instruction.
interface vrf_ctrl_if import vrf_pkg::*; #(
    parameter int ADDR_B = addr_b(REG_NUM_DEF)
) ();
    logic              issue_valid_i;
    logic              issue_ready_o;
    logic [ADDR_B-1:0] vs1_i;
    logic [ADDR_B-1:0] vs2_i;
    logic [ADDR_B-1:0] vs3_i;
    logic [ADDR_B-1:0] vd_i;
    logic              use_c_i;
    logic              wb_i;

    modport master (
        output issue_valid_i, vs1_i, vs2_i, vs3_i, vd_i, use_c_i, wb_i,
        input  issue_ready_o
    );

    modport slave (
        input  issue_valid_i, vs1_i, vs2_i, vs3_i, vd_i, use_c_i, wb_i,
        output issue_ready_o
    );
endinterface

// File: rtl/vrf_wb_seq.sv
// Write-back sequencer: arms the VRF write port, then writes one element per lane result beat.
module vrf_wb_seq import vrf_pkg::*; #(
    parameter int LANES  = LANES_DEF,
    parameter int ADDR_B = addr_b(REG_NUM_DEF),
    localparam int ELEM_B = elem_b(LANES)
) (
    input  logic              clk_i,
    input  logic              resetn_i,
    input  logic              i_pend_v,
    input  logic              i_pend_set,
    input  logic [ADDR_B-1:0] i_pend_vd,
    input  logic              result_valid_i,
    output logic              result_ready_o,
    output logic              wr_req_o,
    output logic              wr_en_o,
    output logic [ELEM_B-1:0] wr_elem_cnt_o,
    output logic              wr_ready_o,
    output logic [ADDR_B-1:0] wr_addr_o,
    output logic              o_clr
);

    localparam logic [ELEM_B-1:0] LAST = ELEM_B'(LANES - 1);

    wr_state_t         r_state, w_next;
    logic [ELEM_B-1:0] r_wcnt;

    // Arming on the accept itself puts wr_req one cycle after the issue handshake.
    always_comb begin
        w_next         = r_state;
        result_ready_o = 1'b0;
        wr_req_o       = 1'b0;
        wr_en_o        = 1'b0;
        wr_ready_o     = 1'b0;
        o_clr          = 1'b0;
        case (r_state)
            W_IDLE: if (i_pend_v || i_pend_set) w_next = W_ARM;
            W_ARM: begin
                wr_req_o = 1'b1;
                w_next   = W_DATA;
            end
            W_DATA: begin
                result_ready_o = 1'b1;
                if (result_valid_i) begin
                    wr_en_o = 1'b1;
                    if (r_wcnt == LAST) begin
                        wr_ready_o = 1'b1;
                        o_clr      = 1'b1;
                        w_next     = W_IDLE;
                    end
                end
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_state <= W_IDLE;
            r_wcnt  <= '0;
        end else begin
            r_state <= w_next;
            if (wr_en_o) r_wcnt <= (r_wcnt == LAST) ? '0 : r_wcnt + 1'b1;
        end
    end

    assign wr_elem_cnt_o = r_wcnt;
    assign wr_addr_o     = i_pend_vd;

endmodule

// File: rtl/vrf_ctrl.sv
// VRF sequencer top: operand fetch and element streaming to the lanes, single pending
// write-back tag with RAW hazard stall, and the write-back sequencer.
module vrf_ctrl import vrf_pkg::*; #(
    parameter int REG_NUM = REG_NUM_DEF,
    parameter int LANES   = LANES_DEF,
    localparam int ADDR_B = addr_b(REG_NUM),
    localparam int ELEM_B = elem_b(LANES)
) (
    input  logic              clk_i,
    input  logic              resetn_i,
    vrf_ctrl_if.slave         iss,
    output logic [ADDR_B-1:0] a_addr_o,
    output logic [ADDR_B-1:0] b_addr_o,
    output logic [ADDR_B-1:0] c_addr_o,
    output logic [ADDR_B-1:0] wr_addr_o,
    output logic              rd_req_o,
    output logic              is_c_used_o,
    input  logic              rd_op_ready_i,
    output logic [ELEM_B-1:0] rd_elem_cnt_o,
    output logic              exec_valid_o,
    input  logic              exec_ready_i,
    input  logic              result_valid_i,
    output logic              result_ready_o,
    output logic              wr_req_o,
    output logic              wr_en_o,
    output logic [ELEM_B-1:0] wr_elem_cnt_o,
    output logic              wr_ready_o,
    output logic              busy_o
);

    localparam logic [ELEM_B-1:0] LAST = ELEM_B'(LANES - 1);

    rd_state_t         r_rstate, w_rnext;
    logic [ELEM_B-1:0] r_rcnt;
    logic [ADDR_B-1:0] r_a, r_b, r_c, r_pend_vd;
    logic              r_use_c, r_pend_v;
    logic              w_hazard, w_accept, w_pend_set, w_clr, w_rbeat;

    // Stall decision uses only registered state and issue inputs, never lane handshakes.
    assign w_hazard = (iss.vs1_i == r_pend_vd) || (iss.vs2_i == r_pend_vd) ||
                      (iss.use_c_i && (iss.vs3_i == r_pend_vd));
    assign iss.issue_ready_o = (r_rstate == R_IDLE) && !(r_pend_v && (iss.wb_i || w_hazard));
    assign w_accept   = iss.issue_valid_i && iss.issue_ready_o;
    assign w_pend_set = w_accept && iss.wb_i;

    always_comb begin
        w_rnext      = r_rstate;
        rd_req_o     = 1'b0;
        exec_valid_o = 1'b0;
        w_rbeat      = 1'b0;
        case (r_rstate)
            R_IDLE:  if (w_accept) w_rnext = R_FETCH;
            R_FETCH: begin
                rd_req_o = 1'b1;
                w_rnext  = R_WAIT;
            end
            R_WAIT:  if (rd_op_ready_i) w_rnext = R_EXEC;
            R_EXEC: begin
                exec_valid_o = 1'b1;
                if (exec_ready_i) begin
                    w_rbeat = 1'b1;
                    if (r_rcnt == LAST) w_rnext = R_IDLE;
                end
            end
            default: w_rnext = R_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_rstate  <= R_IDLE;
            r_rcnt    <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_c       <= '0;
            r_use_c   <= 1'b0;
            r_pend_v  <= 1'b0;
            r_pend_vd <= '0;
        end else begin
            r_rstate <= w_rnext;
            if (w_rbeat) r_rcnt <= (r_rcnt == LAST) ? '0 : r_rcnt + 1'b1;
            if (w_accept) begin
                r_a     <= iss.vs1_i;
                r_b     <= iss.vs2_i;
                r_c     <= iss.vs3_i;
                r_use_c <= iss.use_c_i;
            end
            // Set and clear never coincide: a wb issue is refused while the tag is live.
            if (w_pend_set) begin
                r_pend_v  <= 1'b1;
                r_pend_vd <= iss.vd_i;
            end else if (w_clr) begin
                r_pend_v  <= 1'b0;
            end
        end
    end

    assign a_addr_o      = r_a;
    assign b_addr_o      = r_b;
    assign c_addr_o      = r_c;
    assign is_c_used_o   = r_use_c;
    assign rd_elem_cnt_o = r_rcnt;
    assign busy_o        = (r_rstate != R_IDLE) || r_pend_v;

    vrf_wb_seq #(
        .LANES  (LANES),
        .ADDR_B (ADDR_B)
    ) u_wb_seq (
        .clk_i          (clk_i),
        .resetn_i       (resetn_i),
        .i_pend_v       (r_pend_v),
        .i_pend_set     (w_pend_set),
        .i_pend_vd      (r_pend_vd),
        .result_valid_i (result_valid_i),
        .result_ready_o (result_ready_o),
        .wr_req_o       (wr_req_o),
        .wr_en_o        (wr_en_o),
        .wr_elem_cnt_o  (wr_elem_cnt_o),
        .wr_ready_o     (wr_ready_o),
        .wr_addr_o      (wr_addr_o),
        .o_clr          (w_clr)
    );

endmodule

// File: tb/tb_vrf_ctrl.sv
// Scoreboard bench for vrf_ctrl: issue stimulus queues expected exec/write beats, a monitor checks them.
module tb_vrf_ctrl;
    import vrf_pkg::*;

    logic       clk_i = 1'b0;
    logic       resetn_i = 1'b0;
    logic [4:0] a_addr_o, b_addr_o, c_addr_o, wr_addr_o;
    logic       rd_req_o, is_c_used_o, rd_op_ready_i, exec_valid_o, exec_ready_i;
    logic       result_valid_i, result_ready_o, wr_req_o, wr_en_o, wr_ready_o, busy_o;
    logic [1:0] rd_elem_cnt_o, wr_elem_cnt_o;

    vrf_ctrl_if #(.ADDR_B(5)) u_if ();

    vrf_ctrl #(.REG_NUM(32), .LANES(4)) u_dut (
        .clk_i          (clk_i),
        .resetn_i       (resetn_i),
        .iss            (u_if),
        .a_addr_o       (a_addr_o),
        .b_addr_o       (b_addr_o),
        .c_addr_o       (c_addr_o),
        .wr_addr_o      (wr_addr_o),
        .rd_req_o       (rd_req_o),
        .is_c_used_o    (is_c_used_o),
        .rd_op_ready_i  (rd_op_ready_i),
        .rd_elem_cnt_o  (rd_elem_cnt_o),
        .exec_valid_o   (exec_valid_o),
        .exec_ready_i   (exec_ready_i),
        .result_valid_i (result_valid_i),
        .result_ready_o (result_ready_o),
        .wr_req_o       (wr_req_o),
        .wr_en_o        (wr_en_o),
        .wr_elem_cnt_o  (wr_elem_cnt_o),
        .wr_ready_o     (wr_ready_o),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {logic [1:0] cnt; logic [4:0] a, b, c; logic cu;} ex_t;
    typedef struct packed {logic [1:0] cnt; logic [4:0] addr; logic last;} wr_t;

    ex_t exq[$];
    wr_t wrq[$];
    int  n_chk = 0, n_fail = 0;
    int  cyc = 0, t_acc = 0, exp_lat = 4;
    int  ex_mode = 0, res_mode = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_idle(input string p);
        chk({p, "_issue_ready"}, u_if.issue_ready_o, 1);
        chk({p, "_ctrl"}, {rd_req_o, exec_valid_o, result_ready_o, wr_req_o, wr_en_o, wr_ready_o, busy_o}, 0);
        chk({p, "_addr"}, {a_addr_o, b_addr_o, c_addr_o, wr_addr_o, is_c_used_o}, 0);
        chk({p, "_cnt"}, {rd_elem_cnt_o, wr_elem_cnt_o}, 0);
    endtask

    task automatic push_entries(input logic [4:0] v1, v2, v3, vd, input logic uc, wb);
        for (int i = 0; i < 4; i++) begin
            exq.push_back('{cnt: 2'(i), a: v1, b: v2, c: v3, cu: uc});
            if (wb) wrq.push_back('{cnt: 2'(i), addr: vd, last: (i == 3)});
        end
    endtask

    task automatic drive_issue(input logic [4:0] v1, v2, v3, vd, input logic uc, wb);
        u_if.vs1_i = v1; u_if.vs2_i = v2; u_if.vs3_i = v3; u_if.vd_i = vd;
        u_if.use_c_i = uc; u_if.wb_i = wb; u_if.issue_valid_i = 1'b1;
    endtask

    task automatic do_issue(input logic [4:0] v1, v2, v3, vd, input logic uc, wb,
                            input int lat, output int waited);
        push_entries(v1, v2, v3, vd, uc, wb);
        @(posedge clk_i); #1;
        drive_issue(v1, v2, v3, vd, uc, wb);
        waited = 0;
        @(negedge clk_i);
        while (!u_if.issue_ready_o && waited < 40) begin
            waited++;
            @(negedge clk_i);
        end
        chk("issue_accept", u_if.issue_ready_o, 1);
        t_acc = cyc;
        exp_lat = lat;
        @(posedge clk_i); #1;
        u_if.issue_valid_i = 1'b0;
    endtask

    task automatic drain(input string nm, input bit only_exec);
        int n = 0;
        while ((exq.size() != 0 || (!only_exec && wrq.size() != 0)) && n < 300) begin
            @(negedge clk_i);
            n++;
        end
        @(negedge clk_i);
        chk(nm, only_exec ? exq.size() : exq.size() + wrq.size(), 0);
    endtask

    initial forever begin
        @(posedge clk_i);
        cyc++;
    end

    // VRF read FSM model: ready two cycles after the request, three with a third operand.
    initial begin
        int cnt = 0;
        rd_op_ready_i = 1'b0;
        forever begin
            @(posedge clk_i); #1;
            rd_op_ready_i = 1'b0;
            if (!resetn_i) cnt = 0;
            else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) rd_op_ready_i = 1'b1;
                end
                if (rd_req_o) cnt = is_c_used_o ? 3 : 2;
            end
        end
    end

    initial begin
        exec_ready_i = 1'b0;
        result_valid_i = 1'b0;
        forever begin
            @(posedge clk_i); #1;
            exec_ready_i   = (ex_mode == 2) ? 1'($urandom_range(0, 1)) : (ex_mode == 1);
            result_valid_i = (res_mode == 2) ? 1'($urandom_range(0, 1)) : (res_mode == 1);
        end
    end

    initial begin
        logic       prev_ev = 1'b0, prev_er = 1'b0;
        logic [1:0] prev_rcnt = '0;
        ex_t e;
        wr_t w;
        forever begin
            @(negedge clk_i);
            if (!resetn_i) begin
                prev_ev = 1'b0;
                continue;
            end
            if (rd_req_o) chk("rd_req_lat", cyc - t_acc, 1);
            if (wr_req_o) chk("wr_req_lat", cyc - t_acc, 1);
            if (exec_valid_o && !prev_ev) chk("first_exec_lat", cyc - t_acc, exp_lat);
            if (exec_valid_o && prev_ev && !prev_er) chk("rd_cnt_hold", rd_elem_cnt_o, prev_rcnt);
            if (exec_valid_o && exec_ready_i) begin
                if (exq.size() == 0) chk("exec_unexpected", exq.size(), 1);
                else begin
                    e = exq.pop_front();
                    chk("exec_beat", {rd_elem_cnt_o, a_addr_o, b_addr_o, c_addr_o, is_c_used_o}, e);
                end
            end
            if (wr_en_o) begin
                if (wrq.size() == 0) chk("wr_unexpected", wrq.size(), 1);
                else begin
                    w = wrq.pop_front();
                    chk("wr_beat", {wr_elem_cnt_o, wr_addr_o, wr_ready_o}, w);
                end
            end
            if (wr_ready_o && !wr_en_o) chk("wr_ready_alone", wr_en_o, 1);
            prev_ev = exec_valid_o;
            prev_er = exec_ready_i;
            prev_rcnt = rd_elem_cnt_o;
        end
    end

    initial begin
        int  w;
        bit  seen;
        drive_issue(5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        u_if.issue_valid_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk_idle("reset");
        @(posedge clk_i); #1;
        resetn_i = 1'b1;

        ex_mode = 1; res_mode = 0;
        do_issue(5'd2, 5'd3, 5'd0, 5'd5, 1'b0, 1'b1, 4, w);
        drain("t1_exec_drain", 1'b1);

        do_issue(5'd8, 5'd9, 5'd7, 5'd0, 1'b1, 1'b0, 5, w);
        chk("t2_no_stall", w, 0);
        drain("t2_exec_drain", 1'b1);

        // RAW hazard on the pending vd=5 until the write-back completes
        push_entries(5'd1, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0);
        @(posedge clk_i); #1;
        drive_issue(5'd1, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0);
        res_mode = 1;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk_i);
            if (wr_ready_o) begin
                chk("stall_at_last_beat", u_if.issue_ready_o, 0);
                seen = 1;
            end else chk("hazard_stall", u_if.issue_ready_o, 0);
        end
        chk("wr_ready_seen", seen, 1);
        @(negedge clk_i);
        chk("ready_after_clear", u_if.issue_ready_o, 1);
        t_acc = cyc; exp_lat = 4;
        @(posedge clk_i); #1;
        u_if.issue_valid_i = 1'b0;
        drain("hazard_drain", 1'b0);

        ex_mode = 2; res_mode = 2;
        do_issue(5'd4, 5'd6, 5'd10, 5'd12, 1'b1, 1'b1, 5, w);
        do_issue(5'd1, 5'd14, 5'd0, 5'd0, 1'b0, 1'b0, 4, w);
        drain("throttle_drain", 1'b0);

        // Reset while parked in R_EXEC and W_DATA
        ex_mode = 0; res_mode = 0;
        do_issue(5'd2, 5'd3, 5'd0, 5'd9, 1'b0, 1'b1, 4, w);
        for (int i = 0; i < 20 && !exec_valid_o; i++) @(negedge clk_i);
        chk("exec_reached", exec_valid_o, 1);
        chk("wdata_reached", result_ready_o, 1);
        @(negedge clk_i); #2;
        resetn_i = 1'b0;
        #1;
        chk_idle("rst_mid");
        exq.delete();
        wrq.delete();
        repeat (2) @(posedge clk_i);
        #1;
        resetn_i = 1'b1;
        ex_mode = 1; res_mode = 1;
        do_issue(5'd3, 5'd4, 5'd0, 5'd6, 1'b0, 1'b1, 4, w);
        drain("post_reset_drain", 1'b0);

        repeat (3) @(negedge clk_i);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
